// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the single-cycle datapath's memory request unit.
package cpu_types_pkg;

   // Legacy-compatible state encodings, reused as the enum values below
   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   typedef enum logic [1:0] {
      FETCH  = ST_FETCH,
      DATA   = ST_DATA,
      HALTED = ST_HALTED
   } mru_state_e;

   // Widest supported performance counter and its saturation value
   localparam int unsigned            CNT_W_MAX = 32;
   localparam logic [CNT_W_MAX-1:0]   CNT_MAX   = '1;

   // Saturation value of a counter that is w bits wide (w in 1..CNT_W_MAX)
   function automatic logic [CNT_W_MAX-1:0] cnt_max(input int unsigned w);
      return CNT_MAX >> (CNT_W_MAX - w);
   endfunction

endpackage

// File: rtl/request_unit_if.sv
// Bundles the request unit's control, memory handshake and status signals.
interface request_unit_if #(
   parameter int unsigned CNT_W = 32
) (
   input logic CLK
);
   logic             RST;
   logic             Iren;
   logic             Dren;
   logic             Dwen;
   logic             halt;
   logic             ihit;
   logic             dhit;
   logic             imemREN;
   logic             dmemREN;
   logic             dmemWEN;
   logic             pc_en;
   logic             halted;
   logic             req_err;
   logic [CNT_W-1:0] instr_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport req (
      input  CLK, RST, Iren, Dren, Dwen, halt, ihit, dhit,
      output imemREN, dmemREN, dmemWEN, pc_en, halted, req_err, instr_cnt, stall_cnt
   );

   modport tb (
      input  CLK, imemREN, dmemREN, dmemWEN, pc_en, halted, req_err, instr_cnt, stall_cnt,
      output RST, Iren, Dren, Dwen, halt, ihit, dhit
   );

endinterface

// File: rtl/sat_counter.sv
// W-bit up counter that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Clear wins over increment; increment stops once all bits are set
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/mem_request_unit.sv
// Sequences instruction and data memory requests, retires instructions via
// pc_en, latches halt and keeps saturating retire/stall counters.
module mem_request_unit
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Iren,
   input  logic             Dren,
   input  logic             Dwen,
   input  logic             halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halted,
   output logic             req_err,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   mru_state_e state;
   mru_state_e state_nxt;
   logic       rd;
   logic       wr;

   logic in_fetch;
   logic in_data;
   logic fetch_hit;
   logic fetch_halt;
   logic fetch_data;
   logic fetch_retire;
   logic data_retire;
   logic stall;
   logic instr_inc;

   // Decode this cycle's events; halt outranks a data op, which outranks a plain retire
   always_comb begin
      in_fetch     = (state == FETCH);
      in_data      = (state == DATA);
      fetch_hit    = in_fetch & Iren & ihit;
      fetch_halt   = fetch_hit & halt;
      fetch_data   = fetch_hit & ~halt & (Dren | Dwen);
      fetch_retire = fetch_hit & ~halt & ~Dren & ~Dwen;
      data_retire  = in_data & dhit;
      stall        = (in_fetch & Iren & ~ihit) | (in_data & ~dhit);
      instr_inc    = fetch_retire | data_retire | fetch_halt;
   end

   // Request and status outputs from registered state and latched request bits
   always_comb begin
      imemREN = in_fetch & Iren;
      dmemREN = in_data & rd;
      dmemWEN = in_data & wr;
      pc_en   = fetch_retire | data_retire;
      halted  = (state == HALTED);
   end

   // Next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (fetch_halt) begin
               state_nxt = HALTED;
            end else if (fetch_data) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (dhit) begin
               state_nxt = FETCH;
            end
         end
         HALTED:  state_nxt = HALTED;
         default: state_nxt = FETCH;
      endcase
   end

   // State register, data request latches and the sticky conflict flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= FETCH;
         rd      <= 1'b0;
         wr      <= 1'b0;
         req_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fetch_data) begin
            // A simultaneous read and write resolves to the write
            rd <= Dren & ~Dwen;
            wr <= Dwen;
            if (Dren && Dwen) begin
               req_err <= 1'b1;
            end
         end else if (data_retire) begin
            rd <= 1'b0;
            wr <= 1'b0;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk (CLK),
      .clr (RST),
      .inc (instr_inc),
      .q   (instr_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (CLK),
      .clr (RST),
      .inc (stall),
      .q   (stall_cnt)
   );

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: directed and random stimulus, a
// transaction-level reference model, and a monitor that checks every cycle.
module tb_mem_request_unit;
   import cpu_types_pkg::*;

   localparam int unsigned W    = 8;
   localparam int          MAXC = (1 << W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   request_unit_if #(.CNT_W(W)) ruif (.CLK(clk));

   mem_request_unit #(.CNT_W(W)) dut (
      .CLK       (clk),
      .RST       (ruif.RST),
      .Iren      (ruif.Iren),
      .Dren      (ruif.Dren),
      .Dwen      (ruif.Dwen),
      .halt      (ruif.halt),
      .ihit      (ruif.ihit),
      .dhit      (ruif.dhit),
      .imemREN   (ruif.imemREN),
      .dmemREN   (ruif.dmemREN),
      .dmemWEN   (ruif.dmemWEN),
      .pc_en     (ruif.pc_en),
      .halted    (ruif.halted),
      .req_err   (ruif.req_err),
      .instr_cnt (ruif.instr_cnt),
      .stall_cnt (ruif.stall_cnt)
   );

   typedef struct {
      int imem;
      int dren;
      int dwen;
      int pc;
      int halted;
      int err;
      int icnt;
      int scnt;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: what the unit is waiting for, not how it encodes it
   bit m_known  = 1'b0;
   bit m_halted = 1'b0;
   bit m_pend   = 1'b0;
   bit m_pw     = 1'b0;
   bit m_err    = 1'b0;
   int m_icnt   = 0;
   int m_scnt   = 0;

   function automatic int sat_inc(input int v);
      return (v < MAXC) ? v + 1 : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: drive inputs, queue expected outputs, advance model
   task automatic step(input bit r, input bit iren, input bit dren, input bit dwen,
                       input bit hlt, input bit ih, input bit dh);
      exp_t e;
      @(posedge clk);
      #1;
      ruif.RST  = r;
      ruif.Iren = iren;
      ruif.Dren = dren;
      ruif.Dwen = dwen;
      ruif.halt = hlt;
      ruif.ihit = ih;
      ruif.dhit = dh;
      if (m_known) begin
         e.halted = int'(m_halted);
         e.err    = int'(m_err);
         e.icnt   = m_icnt;
         e.scnt   = m_scnt;
         if (m_halted) begin
            e.imem = 0; e.dren = 0; e.dwen = 0; e.pc = 0;
         end else if (m_pend) begin
            e.imem = 0;
            e.dren = int'(!m_pw);
            e.dwen = int'(m_pw);
            e.pc   = int'(dh);
         end else begin
            e.imem = int'(iren);
            e.dren = 0;
            e.dwen = 0;
            e.pc   = int'(iren && ih && !hlt && !dren && !dwen);
         end
         sbq.push_back(e);
      end
      if (r) begin
         m_known = 1'b1; m_halted = 1'b0; m_pend = 1'b0; m_pw = 1'b0;
         m_err = 1'b0; m_icnt = 0; m_scnt = 0;
      end else if (m_known && !m_halted) begin
         if (m_pend) begin
            if (dh) begin
               m_icnt = sat_inc(m_icnt);
               m_pend = 1'b0;
            end else begin
               m_scnt = sat_inc(m_scnt);
            end
         end else if (iren) begin
            if (!ih) begin
               m_scnt = sat_inc(m_scnt);
            end else if (hlt) begin
               m_icnt   = sat_inc(m_icnt);
               m_halted = 1'b1;
            end else if (dren || dwen) begin
               m_pend = 1'b1;
               m_pw   = dwen;
               if (dren && dwen) m_err = 1'b1;
            end else begin
               m_icnt = sat_inc(m_icnt);
            end
         end
      end
   endtask

   // Monitor: compare every presented cycle against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("imemREN",   int'(ruif.imemREN),   e.imem);
            chk("dmemREN",   int'(ruif.dmemREN),   e.dren);
            chk("dmemWEN",   int'(ruif.dmemWEN),   e.dwen);
            chk("pc_en",     int'(ruif.pc_en),     e.pc);
            chk("halted",    int'(ruif.halted),    e.halted);
            chk("req_err",   int'(ruif.req_err),   e.err);
            chk("instr_cnt", int'(ruif.instr_cnt), e.icnt);
            chk("stall_cnt", int'(ruif.stall_cnt), e.scnt);
         end
      end
   end

   initial begin
      ruif.RST = 1'b1; ruif.Iren = 1'b0; ruif.Dren = 1'b0; ruif.Dwen = 1'b0;
      ruif.halt = 1'b0; ruif.ihit = 1'b0; ruif.dhit = 1'b0;

      // Reset, then four zero-wait instructions
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 1, 0, 0, 0, 1, 0);

      // Three fetch stalls then a retire
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);

      // Load with two data wait cycles
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 1, 0);
      repeat (2) step(0, 1, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0);

      // Read and write together: write wins, error is sticky
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);

      // Halt, ignored activity afterwards, reset back to fetch
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 5; i++)
         step(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Spurious ihit without Iren
      step(0, 0, 1, 1, 0, 1, 1);

      // Random traffic, occasional reset to leave the halted state
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 49) == 0,
              1'($urandom),
              1'($urandom));
      end

      // Stall counter saturation, then reset while a load is outstanding
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (300) step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 1);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() != 0) chk("drain", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
